// File: rtl/uart_autobaud_ctrl.sv
// uart_autobaud_ctrl: measures a 0x55 sync character on rxd and derives the UART receiver's baud_rate16 DDS increment
//   clk, rst_n                            clock, asynchronous active-low reset
//   rxd                                   raw serial line, synchronized internally
//   start                                 one-clock pulse, restarts detection from any state
//   rx_data, rx_data_ready, framing_error UART receiver outputs
//   baud_rate16                           DDS increment, 2^28 / clocks-per-bit
//   locked, busy                          rate valid / measuring or dividing
//   detect_error                          one-clock pulse on a failed detection
//   out_data, out_valid                   receiver bytes forwarded while locked
//   UART_AUTOBAUD_RELOCK_EN               when defined, FERR_MAX consecutive framing errors force a relock
module uart_autobaud_ctrl #(
  parameter int          MEAS_W         = 20,
  parameter logic [23:0] DEFAULT_BAUD16 = 24'd309238,
  parameter int          IDLE_CLKS      = 1024,
  parameter int          FERR_MAX       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_ready,
  input  logic        framing_error,
  output logic [23:0] baud_rate16,
  output logic        locked,
  output logic        busy,
  output logic        detect_error,
  output logic [7:0]  out_data,
  output logic        out_valid
);
  typedef enum logic [2:0] {HUNT_IDLE, WAIT_START, MEASURE, DIVIDE, SETTLE, LOCKED} state_t;
  localparam int HW = MEAS_W + 1;
  state_t state;
  logic rx_m, rx_s, rx_d, tog, ge, too_short, seg_bad;
  logic [MEAS_W-1:0] n, s, s0, n8, n_inc, r;
  logic [MEAS_W:0] hcnt, seg, lo, hi, rsh;
  logic [2:0] e;
  logic [31:0] q;
  logic [5:0] dcnt;
`ifdef UART_AUTOBAUD_RELOCK_EN
  localparam int FW = $clog2(FERR_MAX + 1);
  logic [FW-1:0] ferr;
`else
  logic unused_ferr;
  assign unused_ferr = framing_error | (FERR_MAX < 0);
`endif
  assign tog = rx_s ^ rx_d;
  assign n_inc = n + MEAS_W'(1);
  // segment length includes the edge cycle itself, so N8 equals the full 8-bit span
  assign seg = {1'b0, s} + HW'(1);
  assign lo = {1'b0, s0} - {2'b00, s0[MEAS_W-1:2]};
  assign hi = {1'b0, s0} + {2'b00, s0[MEAS_W-1:2]};
  // first edge after the start bit is rising, so the expected level alternates with e
  assign seg_bad = (rx_s == e[0]) || (e != 3'd0 && (seg < lo || seg > hi));
  assign too_short = n_inc < MEAS_W'(129);
  // remainder stays below n8, so the subtraction is done modulo 2^MEAS_W
  assign rsh = {r, q[31]};
  assign ge = rsh >= {1'b0, n8};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
      state <= HUNT_IDLE;
      hcnt <= '0;
      n <= '0;
      s <= '0;
      s0 <= '0;
      n8 <= '0;
      e <= '0;
      q <= '0;
      r <= '0;
      dcnt <= '0;
      baud_rate16 <= DEFAULT_BAUD16;
      locked <= 1'b0;
      busy <= 1'b0;
      detect_error <= 1'b0;
      out_data <= '0;
      out_valid <= 1'b0;
`ifdef UART_AUTOBAUD_RELOCK_EN
      ferr <= '0;
`endif
    end else begin
      rx_m <= rxd;
      rx_s <= rx_m;
      rx_d <= rx_s;
      detect_error <= 1'b0;
      out_valid <= 1'b0;
      if (start) begin
        state <= HUNT_IDLE;
        hcnt <= '0;
        locked <= 1'b0;
        busy <= 1'b0;
      end else begin
        case (state)
          HUNT_IDLE: begin
            hcnt <= rx_s ? hcnt + HW'(1) : '0;
            if (rx_s && hcnt == HW'(IDLE_CLKS - 1)) begin
              state <= WAIT_START;
              hcnt <= '0;
            end
          end
          WAIT_START: if (rx_d && !rx_s) begin
            n <= '0;
            s <= '0;
            e <= '0;
            state <= MEASURE;
            busy <= 1'b1;
          end
          MEASURE: begin
            n <= n_inc;
            s <= s + MEAS_W'(1);
            if (&n || (tog && (seg_bad || (e == 3'd7 && too_short)))) begin
              state <= HUNT_IDLE;
              busy <= 1'b0;
              detect_error <= 1'b1;
            end else if (tog) begin
              e <= e + 3'd1;
              s <= '0;
              if (e == 3'd0) s0 <= seg[MEAS_W-1:0];
              if (e == 3'd7) begin
                n8 <= n_inc;
                q <= 32'h8000_0000;
                r <= '0;
                dcnt <= '0;
                state <= DIVIDE;
              end
            end
          end
          DIVIDE: if (dcnt == 6'd32) begin
            baud_rate16 <= q[23:0];
            state <= SETTLE;
            busy <= 1'b0;
          end else begin
            q <= {q[30:0], ge};
            r <= ge ? rsh[MEAS_W-1:0] - n8 : rsh[MEAS_W-1:0];
            dcnt <= dcnt + 6'd1;
          end
          SETTLE: begin
            hcnt <= rx_s ? hcnt + HW'(1) : '0;
            if (rx_s && hcnt == {n8, 1'b0} - HW'(1)) begin
              state <= LOCKED;
              locked <= 1'b1;
              hcnt <= '0;
`ifdef UART_AUTOBAUD_RELOCK_EN
              ferr <= '0;
`endif
            end
          end
          LOCKED: begin
            out_valid <= rx_data_ready;
            if (rx_data_ready) out_data <= rx_data;
`ifdef UART_AUTOBAUD_RELOCK_EN
            if (rx_data_ready) begin
              ferr <= framing_error ? ferr + FW'(1) : '0;
              if (framing_error && ferr == FW'(FERR_MAX - 1)) begin
                state <= HUNT_IDLE;
                locked <= 1'b0;
                detect_error <= 1'b1;
                ferr <= '0;
              end
            end
`endif
          end
          default: state <= HUNT_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// tb_uart_autobaud_ctrl: directed and randomized sync characters checked against an arithmetic reference model
module tb_uart_autobaud_ctrl;
  localparam logic [23:0] DEF = 24'd309238;
  logic clk = 1'b0;
  logic rst_n, rxd, start, rx_data_ready, framing_error, locked, busy, detect_error, out_valid;
  logic [7:0] rx_data, out_data;
  logic [23:0] baud_rate16, exp_baud;
  int checks = 0, errors = 0, dpulses = 0;
  uart_autobaud_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .start(start), .rx_data(rx_data),
    .rx_data_ready(rx_data_ready), .framing_error(framing_error), .baud_rate16(baud_rate16),
    .locked(locked), .busy(busy), .detect_error(detect_error), .out_data(out_data), .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (detect_error) dpulses++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic clocks(input int c);
    repeat (c) @(negedge clk);
  endtask
  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic drive_sync(input int sg[8]);
    for (int i = 0; i < 8; i++) begin
      rxd = i[0];
      repeat (sg[i]) @(negedge clk);
    end
    rxd = 1'b0;
  endtask
  task automatic strobe(input logic [7:0] d, input logic fe, output logic ov, output logic [7:0] od);
    rx_data = d;
    framing_error = fe;
    rx_data_ready = 1'b1;
    @(negedge clk);
    ov = out_valid;
    od = out_data;
    rx_data_ready = 1'b0;
    framing_error = 1'b0;
    @(negedge clk);
  endtask
  function automatic void uniform(input int b, output int sg[8]);
    for (int i = 0; i < 8; i++) sg[i] = b;
  endfunction
  function automatic void model(input int sg[8], output logic [23:0] eb, output int ed);
    int s0, tot;
    bit bad;
    s0 = sg[0];
    tot = 0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tot += sg[i];
      if (i > 0 && (sg[i] < s0 - s0 / 4 || sg[i] > s0 + s0 / 4)) bad = 1'b1;
    end
    if (tot < 129) bad = 1'b1;
    ed = bad ? 1 : 0;
    eb = bad ? exp_baud : 24'((64'd1 << 31) / longint'(tot));
  endfunction
  initial begin
    int sg[8];
    int d0, ed;
    logic ov;
    logic [7:0] od;
    logic [23:0] eb;
    rst_n = 1'b0;
    rxd = 1'b1;
    start = 1'b0;
    rx_data_ready = 1'b0;
    framing_error = 1'b0;
    rx_data = 8'h00;
    clocks(3);
    chk("rst_baud", 32'(baud_rate16), 32'(DEF));
    chk("rst_locked", 32'(locked), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_det", 32'(detect_error), 0);
    chk("rst_ovalid", 32'(out_valid), 0);
    chk("rst_odata", 32'(out_data), 0);
    rst_n = 1'b1;
    exp_baud = DEF;
    clocks(1100);
    d0 = dpulses;
    uniform(100, sg);
    model(sg, eb, ed);
    drive_sync(sg);
    clocks(30);
    chk("div_busy", 32'(busy), 1);
    chk("div_baud_hold", 32'(baud_rate16), 32'(DEF));
    clocks(10);
    chk("div_done_busy", 32'(busy), 0);
    chk("baud_800", 32'(baud_rate16), 32'd2684354);
    exp_baud = eb;
    clocks(60);
    rxd = 1'b1;
    clocks(1500);
    chk("settle_unlocked", 32'(locked), 0);
    clocks(200);
    chk("settle_locked", 32'(locked), 1);
    chk("nominal_det", 32'(dpulses - d0), 0);
    strobe(8'hA7, 1'b0, ov, od);
    chk("fwd_valid", 32'(ov), 1);
    chk("fwd_data", 32'(od), 32'h A7);
    chk("fwd_valid_drop", 32'(out_valid), 0);
    d0 = dpulses;
`ifdef UART_AUTOBAUD_RELOCK_EN
    for (int i = 0; i < 7; i++) strobe(8'(i), i != 3, ov, od);
    chk("ferr_3c3_locked", 32'(locked), 1);
    chk("ferr_3c3_det", 32'(dpulses - d0), 0);
    strobe(8'h5C, 1'b1, ov, od);
    chk("ferr4_fwd_valid", 32'(ov), 1);
    chk("ferr4_fwd_data", 32'(od), 32'h5C);
    chk("ferr4_unlocked", 32'(locked), 0);
    chk("ferr4_det", 32'(dpulses - d0), 1);
`else
    for (int i = 0; i < 4; i++) strobe(8'(i), 1'b1, ov, od);
    chk("ferr_ignored_locked", 32'(locked), 1);
    chk("ferr_ignored_det", 32'(dpulses - d0), 0);
`endif
    pulse_start;
    chk("start_locked", 32'(locked), 0);
    chk("start_busy", 32'(busy), 0);
    clocks(1100);
    d0 = dpulses;
    uniform(868, sg);
    model(sg, eb, ed);
    drive_sync(sg);
    clocks(60);
    rxd = 1'b1;
    chk("baud_6944", 32'(baud_rate16), 32'd309257);
    chk("det_6944", 32'(dpulses - d0), 0);
    chk("busy_6944", 32'(busy), 0);
    exp_baud = eb;
    clocks(20);
    strobe(8'hA7, 1'b0, ov, od);
    chk("settle_drop", 32'(ov), 0);
    chk("settle_not_locked", 32'(locked), 0);
    pulse_start;
    clocks(1100);
    d0 = dpulses;
    uniform(100, sg);
    sg[4] = 140;
    drive_sync(sg);
    clocks(60);
    rxd = 1'b1;
    chk("tol_det", 32'(dpulses - d0), 1);
    chk("tol_busy", 32'(busy), 0);
    chk("tol_baud", 32'(baud_rate16), 32'(exp_baud));
    clocks(1100);
    d0 = dpulses;
    uniform(15, sg);
    drive_sync(sg);
    clocks(60);
    rxd = 1'b1;
    chk("short_det", 32'(dpulses - d0), 1);
    chk("short_baud", 32'(baud_rate16), 32'(exp_baud));
    clocks(1100);
    uniform(100, sg);
    drive_sync(sg);
    clocks(10);
    chk("abort_busy_before", 32'(busy), 1);
    pulse_start;
    chk("abort_busy_after", 32'(busy), 0);
    clocks(60);
    rxd = 1'b1;
    chk("abort_baud", 32'(baud_rate16), 32'(exp_baud));
    chk("abort_locked", 32'(locked), 0);
    for (int t = 0; t < 6; t++) begin
      int b;
      b = int'($urandom_range(150, 14));
      for (int i = 0; i < 8; i++) sg[i] = b * int'($urandom_range(120, 80)) / 100;
      model(sg, eb, ed);
      clocks(1100);
      d0 = dpulses;
      drive_sync(sg);
      clocks(60);
      rxd = 1'b1;
      chk("rand_det", 32'(dpulses - d0), 32'(ed));
      chk("rand_baud", 32'(baud_rate16), 32'(eb));
      chk("rand_busy", 32'(busy), 0);
      exp_baud = eb;
      pulse_start;
    end
    clocks(1100);
    uniform(100, sg);
    drive_sync(sg);
    clocks(60);
    rxd = 1'b1;
    clocks(500);
    chk("pre_reset_baud", 32'(baud_rate16), 32'd2684354);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_baud", 32'(baud_rate16), 32'(DEF));
    chk("async_rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    clocks(5);
    chk("post_rst_baud", 32'(baud_rate16), 32'(DEF));
    chk("post_rst_locked", 32'(locked), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_autobaud_ctrl.md
Name: uart_autobaud_ctrl

Overview:
Automatic baud-rate controller for the 8-bit UART receiver. It measures a 0x55 sync character on the raw rxd line and computes the receiver's baud_rate16 DDS increment (2^28/clocks-per-bit). It then waits for line idle and gates the receiver's byte stream so nothing is forwarded before lock. It sits between the pin and the UART receiver: it drives the receiver's baud_rate16 input and consumes the receiver's outputs.

Parameters:
MEAS_W, 20, width of the measurement counters; longest measurable 8-bit span is 2^MEAS_W-1 clocks.
DEFAULT_BAUD16, 24'd309238, baud_rate16 value after reset (115200 baud at 100 MHz).
IDLE_CLKS, 1024, consecutive high clocks required on rxd before hunting for a start edge.
FERR_MAX, 4, consecutive framing errors that trigger relock (used only with the optional feature).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rxd  in  1  raw serial line, asynchronous to clk
start  in  1  one-clock pulse: restart detection from any state
rx_data  in  8  byte from UART receiver
rx_data_ready  in  1  receiver byte strobe
framing_error  in  1  receiver framing error flag
baud_rate16  out  24  DDS increment to the UART receiver
locked  out  1  rate valid, forwarding enabled
busy  out  1  high in MEASURE or DIVIDE
detect_error  out  1  one-clock pulse on a failed detection
out_data  out  8  forwarded byte
out_valid  out  1  forwarded byte strobe

Behaviour:
- Reset values: baud_rate16=DEFAULT_BAUD16; all other outputs 0; state HUNT_IDLE. rxd passes through a 2-flop synchronizer whose flops reset to 1. All edge and timing decisions use the synchronized signal.
- HUNT_IDLE: count consecutive high cycles; any low cycle clears the count. At IDLE_CLKS go to WAIT_START.
- WAIT_START: on a falling edge, clear total counter N and segment counter S, set edge count E=0, then go to MEASURE.
- MEASURE (busy=1): N and S increment every clock.
  - On each edge: E increments and S restarts.
  - The first segment (start bit) is latched as S0.
  - Each later segment must satisfy S0-(S0>>2) <= S <= S0+(S0>>2).
  - An edge must alternate in polarity from the previous edge.
  - At E=8 (fourth falling edge after start), latch N8=N and go to DIVIDE.
  - Errors: a segment out of tolerance, N reaching 2^MEAS_W-1, or N8<129. Each error pulses detect_error for one clock and returns to HUNT_IDLE.
- DIVIDE (busy=1): restoring divide of 2^31 by N8, one quotient bit per clock, 32 clocks. The result is truncated, and N8>=129 guarantees it fits in 24 bits. On the clock after the last iteration, baud_rate16 takes the quotient and the state goes to SETTLE.
- SETTLE: count consecutive high cycles up to 2*N8 (16 bit periods), restarting on any low cycle. At 2*N8 go to LOCKED.
- LOCKED: locked=1. out_valid and out_data are registered from rx_data_ready and rx_data with 1-clock latency. Outside LOCKED, out_valid=0 and receiver strobes are dropped.
- start, from any state: takes priority over every same-clock event. Next clock: state HUNT_IDLE, locked=0, busy=0, and any in-flight divide is discarded. baud_rate16 holds its last value until a new quotient is loaded.
- An asynchronous reset mid-operation restores all reset values, including DEFAULT_BAUD16.

Optional Feature:
UART_AUTOBAUD_RELOCK_EN
- Defined: in LOCKED, a counter counts consecutive rx_data_ready strobes that have framing_error=1, and a clean strobe clears it. Reaching FERR_MAX has three effects on the next clock: locked drops, detect_error pulses, and the state goes to HUNT_IDLE. The byte with the errored strobe is still forwarded.
- Undefined: framing_error is ignored, the counter is absent, and the block leaves LOCKED only on start or reset.

Test Plan:
- Line idle 1024 clks, then 0x55 with 100-clk bits -> N8=800; baud_rate16=0x28F5C2 (2684354) 33 clks after the 8th edge; locked=1 after 1600 further high clks.
- 0x55 with 868-clk bits (N8=6944) -> baud_rate16=309257, detect_error stays 0.
- 0x55 whose bit 3 is 140 clks against a 100-clk start bit -> detect_error one-clock pulse at that edge, state HUNT_IDLE, baud_rate16 unchanged.
- 0x55 with 15-clk bits (N8=120) -> detect_error, baud_rate16 unchanged; start pulse during DIVIDE -> busy low next clk, baud_rate16 unchanged.
- Locked; rx_data_ready with rx_data=0xA7 -> out_valid and out_data=0xA7 one clk later. The same strobe during SETTLE -> out_valid stays 0.
- With UART_AUTOBAUD_RELOCK_EN, locked; 4 consecutive framing-error strobes -> locked=0 and detect_error pulse. Three errors, one clean strobe, then three errors -> stays locked.
